serial_wide_adder_csla16: RTL
=============================

// Module: serial_wide_adder_csla16
// PURPOSE
//  Multi-word adder that adds WORDS*16-bit operands one 16-bit slice per cycle.
//  Each slice goes through the 16-bit sqrt carry-select adder; the slice carry-out is
//  registered and becomes the next slice's carry-in.
//  Sits directly around the 16-bit carry-select adder: it feeds the adder its operand
//  slices and carry, and consumes the sum and carry-out it produces.
//  Trades latency for area on wide datapaths; uses valid/ready handshakes on both sides.
// PARAMETERS
//  WORDS  default 4  number of 16-bit slices; operand width = 16*WORDS; legal range 1..64
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         operands a, b, cin valid
//  in_ready   out  1         block can accept operands
//  a          in   16*WORDS  operand A, unsigned (two's complement when OVF enabled)
//  b          in   16*WORDS  operand B
//  cin        in   1         carry into bit 0
//  out_valid  out  1         sum and cout valid
//  out_ready  in   1         consumer accepts result
//  sum        out  16*WORDS  a+b+cin mod 2^(16*WORDS)
//  cout       out  1         carry out of the MSB
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0;
//    sum=0; cout=0; internal counters and shift registers = 0.
//  - FSM has three states:
//    - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b and cin into shift
//      registers, clear the slice counter, then go to RUN.
//    - RUN: in_ready=0, out_valid=0. Each cycle the adder sees a_sh[15:0], b_sh[15:0]
//      and carry_reg. The slice sum shifts into the MSB end of sum_sh; a_sh and b_sh
//      shift right by 16; carry_reg takes the slice cout; cnt increments.
//      When cnt==WORDS-1, go to DONE.
//    - DONE: out_valid=1; sum=sum_sh; cout=carry_reg. Hold both stable while !out_ready.
//      On out_ready, go to IDLE.
//  - Latency: accept at edge T, out_valid high from edge T+WORDS.
//    WORDS=1 gives exactly one RUN cycle.
//  - No overlap between operations: in_ready stays 0 from accept until the cycle after
//    result handshake. No same-cycle accept in DONE.
//  - out_ready already high on DONE entry: out_valid is high for exactly one cycle.
//  - in_valid while busy: ignored. The upstream must hold its operands.
//  - out_ready asserted in IDLE or RUN: no effect.
//  - Reset mid-RUN or mid-DONE: operation aborted, result discarded, all outputs take
//    reset values.
//  - Arithmetic is modulo 2^(16*WORDS); cout is the final registered carry.
// CONFIGURATION
//  Macro SERIAL_ADDER_OVF_EN:
//  - Defined: adds output port ovf (out, 1) = signed overflow,
//    i.e. carry into MSB XOR carry out of MSB. It is captured in the last RUN cycle
//    from the top slice: a[MSB]==b[MSB] && sum[MSB]!=a[MSB]. Valid with out_valid,
//    held under backpressure, reset 0.
//  - Undefined: no ovf port and no extra logic.
// STRUCTURE
//  - Shared include header (adder_defs.vh):
//    - localparam SLICE_W=16
//    - FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//    - localparam for counter width: $clog2(WORDS), min 1
//  - Sub-module: one instance of carry_select_adder_rca_16_sqrt as the slice datapath.
//  - Everything else (FSM, shift registers, counter, carry register) is local.
// TESTING
//  1. WORDS=4, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0
//     -> sum=0, cout=1, out_valid exactly 4 cycles after accept.
//  2. a=0, b=0, cin=1 -> sum=1, cout=0.
//     Then a=64'h0000_FFFF_0000_FFFF, b=64'h1_0000_0001, cin=0
//     -> sum=64'h0001_0000_0001_0000 (inter-slice carry).
//  3. Backpressure: out_ready=0 for 5 cycles after out_valid
//     -> sum/cout stable, in_ready=0. Release -> IDLE next cycle, in_ready=1.
//  4. rst_n low during 2nd RUN cycle -> out_valid=0, in_ready=1, sum=0, cout=0;
//     next operation correct.
//  5. Back-to-back random traffic: 1000 ops with random in_valid/out_ready gaps,
//     WORDS in {1,4,7} -> every result equals the golden a+b+cin; no lost or duplicated ops.
//  6. SERIAL_ADDER_OVF_EN, WORDS=4: a=64'h7FFF_FFFF_FFFF_FFFF, b=1 -> ovf=1.
//     a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> ovf=0, cout=1.

Source files
------------

// File: rtl/serial_wide_adder_csla16_pkg.sv
// Shared constants, FSM state type and sizing helper for the serial wide adder.
package serial_wide_adder_csla16_pkg;

    localparam int unsigned SLICE_W = 16;

    // Square-root group partition of the 16-bit slice: 2+2+3+4+5.
    localparam int unsigned GRP_N = 5;
    localparam int unsigned GRP_LO [GRP_N] = '{0, 2, 4, 7, 11};
    localparam int unsigned GRP_W  [GRP_N] = '{2, 2, 3, 4, 5};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/serial_wide_adder_csla16_csa.sv
// 16-bit square-root carry-select adder: each group precomputes sums for both
// carry-in values and the incoming group carry selects one.
module carry_select_adder_rca_16_sqrt
    import serial_wide_adder_csla16_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    logic [GRP_N:0] c_grp;

    assign c_grp[0] = cin_i;

    for (genvar g = 0; g < GRP_N; g++) begin : g_grp
        localparam int unsigned LO = GRP_LO[g];
        localparam int unsigned W  = GRP_W[g];
        localparam logic [W:0]  ONE = {{W{1'b0}}, 1'b1};

        logic [W:0] r0;
        logic [W:0] r1;

        // r0 tops out at 2^(W+1)-2, so r0+1 never overflows W+1 bits.
        assign r0 = {1'b0, a_i[LO +: W]} + {1'b0, b_i[LO +: W]};
        assign r1 = r0 + ONE;

        assign sum_o[LO +: W] = c_grp[g] ? r1[W-1:0] : r0[W-1:0];
        assign c_grp[g+1]     = c_grp[g] ? r1[W]     : r0[W];
    end

    assign cout_o = c_grp[GRP_N];

endmodule

// File: rtl/serial_wide_adder_csla16.sv
// Serial multi-word adder: one 16-bit carry-select slice per cycle, valid/ready on both sides.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_wide_adder_csla16
    import serial_wide_adder_csla16_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    input  logic                       cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   sum,
    output logic                       cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic                       ovf
`endif
);

    localparam int unsigned W     = SLICE_W * WORDS;
    localparam int unsigned CNT_W = cnt_width(WORDS);

    state_e             state_q, state_d;
    logic [W-1:0]       a_sh_q, a_sh_d;
    logic [W-1:0]       b_sh_q, b_sh_d;
    logic [W-1:0]       sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               last_slice;

    carry_select_adder_rca_16_sqrt u_slice (
        .a_i    (a_sh_q[SLICE_W-1:0]),
        .b_i    (b_sh_q[SLICE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    assign last_slice = (cnt_q == CNT_W'(WORDS - 1));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> SLICE_W;
                b_sh_d   = b_sh_q >> SLICE_W;
                // Concatenate-then-shift also covers WORDS==1 without an empty slice.
                sum_sh_d = W'({slice_sum, sum_sh_q} >> SLICE_W);
                carry_d  = slice_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_slice) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_RUN && last_slice) begin
            ovf_d = (a_sh_q[SLICE_W-1] == b_sh_q[SLICE_W-1]) &&
                    (slice_sum[SLICE_W-1] != a_sh_q[SLICE_W-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_sh_q;
    assign cout      = carry_q;

endmodule
